// File: rtl/ap_result_collector_pkg.sv
// Shared definitions for the dot-product result path: default geometry,
// collector state encoding and a small sizing helper.
package ap_result_collector_pkg;

    // Default result width and results packed per AP memory word.
    localparam int unsigned ApElementWidth = 32;
    localparam int unsigned ApNoOfUnits    = 8;
    localparam int unsigned ApAddrWidth    = 10;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDone    = 2'd2
    } ap_state_e;

    // Width of a lane index; a single-lane word still needs one bit.
    function automatic int unsigned calc_lane_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ap_result_collector_if.sv
// Handshake and AP memory write bus of the result collector.
// master: collector side, slave: upstream/memory side.
interface ap_result_collector_if
    import ap_result_collector_pkg::*;
#(
    parameter int unsigned element_width = ApElementWidth,
    parameter int unsigned no_of_units   = ApNoOfUnits,
    parameter int unsigned addr_width    = ApAddrWidth
) ();

    logic                                 start;
    logic [31:0]                          total;
    logic [element_width-1:0]             result;
    logic                                 finish;
    logic [element_width*no_of_units-1:0] AP_wdata;
    logic [addr_width-1:0]                AP_waddr;
    logic                                 AP_total_mem_we;
    logic                                 busy;
    logic                                 done;
    logic                                 err;

    modport master (
        input  start, total, result, finish,
        output AP_wdata, AP_waddr, AP_total_mem_we, busy, done, err
    );

    modport slave (
        output start, total, result, finish,
        input  AP_wdata, AP_waddr, AP_total_mem_we, busy, done, err
    );

endinterface

// File: rtl/ap_word_packer.sv
// Packing buffer for one AP memory word. Results are inserted lane by lane;
// word_o already includes the lane being inserted this cycle so the collector
// can capture a completed word at the same edge that the buffer is cleared.
module ap_word_packer #(
    parameter int unsigned element_width = 32,
    parameter int unsigned no_of_units   = 8,
    parameter int unsigned lane_width    = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear_i,
    input  logic                                 insert_i,
    input  logic                                 flush_i,
    input  logic [lane_width-1:0]                lane_i,
    input  logic [element_width-1:0]             data_i,
    output logic [element_width*no_of_units-1:0] word_o
);

    logic [element_width*no_of_units-1:0] buf_q, buf_d;

    // Merge the incoming result into its lane on top of the held buffer.
    always_comb begin
        word_o = buf_q;
        for (int i = 0; i < int'(no_of_units); i++) begin
            if (insert_i && (lane_i == lane_width'(i))) begin
                word_o[i*element_width +: element_width] = data_i;
            end
        end
    end

    // Buffer next state: emptied on a new run or once its word has been handed off.
    always_comb begin
        buf_d = buf_q;
        if (clear_i) begin
            buf_d = '0;
        end else if (insert_i) begin
            buf_d = flush_i ? '0 : word_o;
        end
    end

    // Buffer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/ap_result_collector.sv
// Collects a run of dot-product results, packs no_of_units of them per AP
// memory word and writes each completed (or final partial) word.
module ap_result_collector
    import ap_result_collector_pkg::*;
#(
    parameter int unsigned element_width = ApElementWidth,
    parameter int unsigned no_of_units   = ApNoOfUnits,
    parameter int unsigned addr_width    = ApAddrWidth
) (
    input logic                   clk,
    input logic                   reset,
    ap_result_collector_if.master bus
);

    localparam int unsigned LaneWidth = calc_lane_width(no_of_units);
    localparam int unsigned WordWidth = element_width * no_of_units;

    ap_state_e             state_q, state_d;
    logic [31:0]           total_q, total_d;
    logic [31:0]           count_q, count_d;
    logic [LaneWidth-1:0]  lane_q, lane_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [WordWidth-1:0]  wdata_q, wdata_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  flush;
    logic                  restart;
    logic                  is_full;
    logic                  is_last;
    logic [WordWidth-1:0]  pack_word;

    assign is_full = (lane_q == LaneWidth'(no_of_units - 1));
    assign is_last = (count_q == (total_q - 32'd1));

    ap_word_packer #(
        .element_width(element_width),
        .no_of_units  (no_of_units),
        .lane_width   (LaneWidth)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (restart),
        .insert_i(accept),
        .flush_i (flush),
        .lane_i  (lane_q),
        .data_i  (bus.result),
        .word_o  (pack_word)
    );

    // FSM next state, counters and write-port next values.
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        count_d = count_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        err_d   = err_q;
        accept  = 1'b0;
        flush   = 1'b0;
        restart = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // A result with no run open is dropped and flagged.
                if (bus.finish) begin
                    err_d = 1'b1;
                end
                if (bus.start) begin
                    err_d = 1'b0;
                    if (bus.total == 32'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StCollect;
                        total_d = bus.total;
                        count_d = '0;
                        lane_d  = '0;
                        addr_d  = '0;
                        restart = 1'b1;
                    end
                end
            end
            StCollect: begin
                // start is ignored while a run is open.
                if (bus.finish) begin
                    accept  = 1'b1;
                    count_d = count_q + 32'd1;
                    lane_d  = is_full ? '0 : lane_q + 1'b1;
                    if (is_full || is_last) begin
                        flush   = 1'b1;
                        we_d    = 1'b1;
                        wdata_d = pack_word;
                        waddr_d = addr_q;
                        addr_d  = addr_q + 1'b1;
                        if (is_last) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            total_q <= '0;
            count_q <= '0;
            lane_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            count_q <= count_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign bus.AP_wdata        = wdata_q;
    assign bus.AP_waddr        = waddr_q;
    assign bus.AP_total_mem_we = we_q;
    assign bus.busy            = (state_q == StCollect);
    assign bus.done            = (state_q == StDone);
    assign bus.err             = err_q;

endmodule

// File: tb/tb_ap_result_collector.sv
// Bench for ap_result_collector: directed scenarios with literal expectations
// plus randomized runs, all checked every cycle against a queue-based model.
module tb_ap_result_collector;

    localparam int unsigned W  = 32;
    localparam int unsigned U  = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned WW = W * U;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    ap_result_collector_if #(.element_width(W), .no_of_units(U), .addr_width(AW)) bus ();

    ap_result_collector #(.element_width(W), .no_of_units(U), .addr_width(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 collecting, 2 done
    int unsigned    m_mode  = 0;
    int unsigned    m_total = 0;
    int unsigned    m_cnt   = 0;
    logic [AW-1:0]  m_addr  = '0;
    logic [W-1:0]   m_lanes[$];
    logic           e_we    = 1'b0;
    logic [WW-1:0]  e_wdata = '0;
    logic [AW-1:0]  e_waddr = '0;
    logic           e_err   = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_total = 0; m_cnt = 0; m_addr = '0;
            m_lanes.delete();
            e_we = 1'b0; e_wdata = '0; e_waddr = '0; e_err = 1'b0;
        end else begin
            e_we = 1'b0;
            if (m_mode != 1) begin
                if (bus.finish) e_err = 1'b1;
                if (bus.start) begin
                    e_err = 1'b0;
                    if (bus.total == 0) begin
                        m_mode = 2;
                    end else begin
                        m_mode = 1; m_total = bus.total; m_cnt = 0; m_addr = '0;
                        m_lanes.delete();
                    end
                end
            end else if (bus.finish) begin
                m_lanes.push_back(bus.result);
                m_cnt++;
                if (m_lanes.size() == U || m_cnt == m_total) begin
                    e_wdata = '0;
                    foreach (m_lanes[i]) e_wdata[i*W +: W] = m_lanes[i];
                    e_waddr = m_addr;
                    m_addr  = m_addr + 1'b1;
                    e_we    = 1'b1;
                    m_lanes.delete();
                    if (m_cnt == m_total) m_mode = 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare and write log ----------------
    logic [AW-1:0] log_addr[$];
    logic [WW-1:0] log_data[$];
    logic          log_done[$];

    always @(negedge clk) begin
        check("we",    WW'(bus.AP_total_mem_we), WW'(e_we));
        check("busy",  WW'(bus.busy),            WW'(m_mode == 1));
        check("done",  WW'(bus.done),            WW'(m_mode == 2));
        check("err",   WW'(bus.err),             WW'(e_err));
        check("waddr", WW'(bus.AP_waddr),        WW'(e_waddr));
        check("wdata", bus.AP_wdata,             e_wdata);
        if (bus.AP_total_mem_we === 1'b1) begin
            log_addr.push_back(bus.AP_waddr);
            log_data.push_back(bus.AP_wdata);
            log_done.push_back(bus.done);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [WW-1:0] build(input int unsigned base, input int unsigned n);
        logic [WW-1:0] w = '0;
        for (int i = 0; i < int'(n); i++) w[i*W +: W] = W'(base + i);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_done.delete();
    endtask

    task automatic do_start(input int unsigned t);
        bus.start = 1'b1; bus.total = t;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] v, input int unsigned gap);
        bus.finish = 1'b1; bus.result = v;
        step();
        bus.finish = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("done_reached", WW'(bus.done), WW'(1));
    endtask

    task automatic check_write(input string name, input int idx,
                               input logic [AW-1:0] addr, input logic [WW-1:0] data,
                               input logic dn);
        if (log_addr.size() > idx) begin
            check({name, "_addr"}, WW'(log_addr[idx]), WW'(addr));
            check({name, "_data"}, log_data[idx], data);
            check({name, "_done"}, WW'(log_done[idx]), WW'(dn));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.start = 1'b0; bus.total = '0; bus.result = '0; bus.finish = 1'b0;
        #1 reset = 1'b1;
        step(); step();
        check("rst_busy",  WW'(bus.busy), '0);
        check("rst_done",  WW'(bus.done), '0);
        check("rst_wdata", bus.AP_wdata,  '0);
        reset = 1'b0;
        step();

        // total=16 back to back: two full words, done with second write
        clear_log();
        do_start(16);
        for (int i = 1; i <= 16; i++) send(W'(i), 0);
        step(); step();
        check("s1_nwrites", WW'(log_addr.size()), WW'(2));
        check_write("s1_w0", 0, 3'd0, build(1, 8), 1'b0);
        check_write("s1_w1", 1, 3'd1, build(9, 8), 1'b1);

        // total=5 with gaps: one partial word
        clear_log();
        do_start(5);
        for (int i = 0; i < 5; i++) send(W'(10 + i), 2);
        step();
        check("s2_nwrites", WW'(log_addr.size()), WW'(1));
        check_write("s2_w0", 0, 3'd0, build(10, 5), 1'b1);

        // total=0: done next cycle, never a write
        clear_log();
        do_start(0);
        check("s3_done", WW'(bus.done), WW'(1));
        repeat (3) step();
        check("s3_nwrites", WW'(log_addr.size()), '0);

        // reset mid-run discards the partial word
        clear_log();
        do_start(8);
        for (int i = 0; i < 3; i++) send(W'(50 + i), 0);
        reset = 1'b1;
        #2;
        check("s4_wdata0", bus.AP_wdata, '0);
        check("s4_busy0",  WW'(bus.busy), '0);
        step();
        reset = 1'b0;
        step();
        do_start(8);
        for (int i = 0; i < 8; i++) send(W'(21 + i), 0);
        step();
        check("s4_nwrites", WW'(log_addr.size()), WW'(1));
        check_write("s4_w0", 0, 3'd0, build(21, 8), 1'b1);

        // finish in idle flags err; next start clears it
        do_reset();
        clear_log();
        send(W'(99), 1);
        check("s5_err", WW'(bus.err), WW'(1));
        check("s5_nwrites", WW'(log_addr.size()), '0);
        do_start(8);
        check("s5_err_clr", WW'(bus.err), '0);
        for (int i = 0; i < 8; i++) send(W'(i), 0);
        step();

        // start during a run is ignored
        clear_log();
        do_start(16);
        for (int i = 1; i <= 5; i++) send(W'(i), 0);
        do_start(4);
        for (int i = 6; i <= 16; i++) send(W'(i), 0);
        step();
        check("s6_nwrites", WW'(log_addr.size()), WW'(2));
        check_write("s6_w0", 0, 3'd0, build(1, 8), 1'b0);
        check_write("s6_w1", 1, 3'd1, build(9, 8), 1'b1);

        // address wraps modulo 2^AW
        clear_log();
        do_start(80);
        for (int i = 0; i < 80; i++) send(W'(i), 0);
        step();
        check("s7_nwrites", WW'(log_addr.size()), WW'(10));
        check_write("s7_w8", 8, 3'd0, build(64, 8), 1'b0);
        check_write("s7_w9", 9, 3'd1, build(72, 8), 1'b1);

        // randomized runs, model checks every cycle
        for (int r = 0; r < 40; r++) begin
            int unsigned t = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            bit aborted = 1'b0;
            do_start(t);
            for (int i = 0; i < int'(t); i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    bus.start = 1'b1; bus.total = $urandom_range(0, 20);
                end
                send($urandom, $urandom_range(0, 2));
                bus.start = 1'b0;
                if ($urandom_range(0, 99) == 0) begin
                    do_reset();
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) wait_done(4);
            if ($urandom_range(0, 3) == 0) send($urandom, 1);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_result_collector.md
AP_RESULT_COLLECTOR -- requirements
Module: ap_result_collector

Interface
REQ-001 SHALL have parameter element_width, default 32, width of one dot-product result.
REQ-002 SHALL have parameter no_of_units, default 8, results packed per AP memory word.
REQ-003 SHALL have parameter addr_width, default 10, AP memory word-address width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a collection run.
REQ-007 SHALL have port total  input  32  number of results expected in the run; sampled on start.
REQ-008 SHALL have port result  input  element_width  dot-product result from the upstream multiply stage.
REQ-009 SHALL have port finish  input  1  result is valid this cycle.
REQ-010 SHALL have port AP_wdata  output  element_width*no_of_units  packed word to AP memory.
REQ-011 SHALL have port AP_waddr  output  addr_width  AP memory word address.
REQ-012 SHALL have port AP_total_mem_we  output  1  write strobe, one cycle per word.
REQ-013 SHALL have port busy  output  1  high in COLLECT.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL implement states IDLE, COLLECT, DONE.
REQ-017 SHALL transition IDLE/DONE -> COLLECT on start with total>0, latching total and clearing lane index, element count, word address, packing buffer and err.
REQ-018 SHALL transition IDLE/DONE -> DONE on start with total==0 (done high next cycle, no write), and clear err.
REQ-019 SHALL ignore start while in COLLECT.
REQ-020 SHALL, in COLLECT, on each finish place result into lane (element count mod no_of_units), lane 0 = least significant bits, and increment the element count.
REQ-021 SHALL, at the edge sampling a finish that fills lane no_of_units-1 or is element total-1, load AP_wdata with the completed word (unfilled lanes zero), load AP_waddr with the current word address, set AP_total_mem_we=1 for exactly the following cycle, clear the buffer, and increment the word address.
REQ-022 SHALL accept finish on every cycle, including the cycle AP_total_mem_we is high, without loss (output register separate from packing buffer).
REQ-023 SHALL enter DONE at the same edge as the final write, so done and the final AP_total_mem_we assert together; done holds until start or reset.
REQ-024 SHALL wrap the word address modulo 2^addr_width without flagging.
REQ-025 SHALL set err on finish sampled in IDLE or DONE, discard that result, and make no write.
REQ-026 SHALL hold AP_wdata and AP_waddr stable between writes.

Reset
REQ-027 SHALL on reset, asynchronously and at any time including mid-run, force state IDLE; set AP_wdata, AP_waddr, AP_total_mem_we, busy, done, err, lane index, element count, latched total and buffer to 0; discard any partial word.

Structure
REQ-028 SHALL place element_width, no_of_units and the state encoding in the shared package used by the dot-product stages.
REQ-029 SHALL implement lane insertion and the packing buffer in one sub-module, ap_word_packer; counters and FSM stay in ap_result_collector.

Verification
REQ-030 SHALL cover: start total=16, results 1..16 on consecutive cycles -> two writes, addr 0 lanes 1..8, addr 1 lanes 9..16, done high with second we.
REQ-031 SHALL cover: start total=5, results 10..14 with 2-cycle gaps -> one write to addr 0, lanes 0..4 = 10..14, lanes 5..7 = 0, done with that we.
REQ-032 SHALL cover: start total=0 -> done=1 next cycle, AP_total_mem_we never asserted.
REQ-033 SHALL cover: total=8, reset after 3 results -> all outputs 0, no write; new start total=8 with 8 results -> single write to addr 0.
REQ-034 SHALL cover: finish in IDLE -> err=1, no write; next start total=8 -> err=0.
REQ-035 SHALL cover: start total=4 during a total=16 run -> ignored, run completes with two writes to addr 0 and 1.
